ifu_pc_gen: RTL and testbench

- Program-counter / next-PC stage directly upstream of the instruction memory.
- Holds the architectural PC and computes the next PC from decode-side control: sequential, branch, jump, jr.
- Drives the word address into the IM and a fetch-valid qualifier.
- Single-cycle datapath style: redirects resolved by decode in the same cycle are applied at the next clock edge.

---
 rtl/ifu_pc_gen_if.sv | 28 ++
 rtl/ifu_pc_gen.sv | 98 +++++++++
 tb/tb_ifu_pc_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pc_gen_if.sv
// Decode-side control and IM-side address signals of the PC generation stage.
// The master modport belongs to the control/consumer side; the slave modport belongs to ifu_pc_gen.
interface ifu_pc_gen_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              stall;
    logic              halt;
    logic [1:0]        npc_sel;
    logic              br_taken;
    logic [15:0]       imm16;
    logic [25:0]       instr_index;
    logic [31:0]       jr_target;
    logic [31:0]       pc;
    logic [31:0]       pc4;
    logic [ADDR_W-1:0] im_addr;
    logic              fetch_valid;
    logic              fault;

    modport master (
        output stall, halt, npc_sel, br_taken, imm16, instr_index, jr_target,
        input  pc, pc4, im_addr, fetch_valid, fault
    );

    modport slave (
        input  stall, halt, npc_sel, br_taken, imm16, instr_index, jr_target,
        output pc, pc4, im_addr, fetch_valid, fault
    );
endinterface

// File: rtl/ifu_pc_gen.sv
// PC / next-PC stage feeding the instruction memory: BOOT -> RUN -> HALT sequencing.
// Optional macro IFU_FAULT_EN adds a sticky FAULT state for misaligned or out-of-range fetches.
module ifu_pc_gen #(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned IM_WORDS = 1024
) (
    input logic          clk,
    input logic          rst_n,
    ifu_pc_gen_if.slave  bus
);

`ifdef IFU_FAULT_EN
    typedef enum logic [1:0] {StBoot, StRun, StHalt, StFault} state_e;
    localparam logic [32:0] PcLimit = {1'b0, PC_BASE} + 33'(4 * IM_WORDS);
`else
    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic [31:0] pc_off;
    logic        fetch_valid;
    logic        fault;

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign pc_off = pc_q - PC_BASE;

    always_comb begin
        npc = pc4;
        unique case (bus.npc_sel)
            2'b00: npc = pc4;
            2'b01: npc = bus.br_taken ? (pc4 + br_off) : pc4;
            2'b10: npc = {pc4[31:28], bus.instr_index, 2'b00};
`ifdef IFU_FAULT_EN
            // Keep the raw target so a misaligned jr can be trapped.
            2'b11: npc = bus.jr_target;
`else
            2'b11: npc = bus.jr_target & ~32'h3;
`endif
            default: npc = pc4;
        endcase
    end

`ifdef IFU_FAULT_EN
    logic npc_bad;
    assign npc_bad = (npc[1:0] != 2'b00) || (npc < PC_BASE) || ({1'b0, npc} >= PcLimit);
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_valid = 1'b0;
        fault       = 1'b0;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                fetch_valid = 1'b1;
                if (bus.halt) begin
                    state_d = StHalt;
                end else if (!bus.stall) begin
                    pc_d = npc;
`ifdef IFU_FAULT_EN
                    if (npc_bad) begin
                        state_d = StFault;
                    end
`endif
                end
            end
            StHalt: state_d = StHalt;
`ifdef IFU_FAULT_EN
            StFault: fault = 1'b1;
`endif
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= PC_BASE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.im_addr     = ADDR_W'(pc_off >> 2);
    assign bus.fetch_valid = fetch_valid;
    assign bus.fault       = fault;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed plus randomized bench for ifu_pc_gen against a cycle-level behavioural model.
// Build with or without IFU_FAULT_EN; the model follows the same macro.
module tb_ifu_pc_gen;
    localparam logic [31:0] PC_BASE  = 32'h0000_3000;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned IM_WORDS = 1024;

    logic clk;
    logic rst_n;

    ifu_pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

    ifu_pc_gen #(
        .PC_BASE (PC_BASE),
        .ADDR_W  (ADDR_W),
        .IM_WORDS(IM_WORDS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: one boot cycle, then fetching until halted or faulted.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halted;
    bit          m_faulted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [1:0] sel, input logic br,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] jr);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        case (sel)
            2'd0: return seq;
            2'd1: return br ? seq + 32'(int'($signed(imm)) * 4) : seq;
            2'd2: return (seq & 32'hF000_0000) + {6'd0, idx} * 32'd4;
`ifdef IFU_FAULT_EN
            default: return jr;
`else
            default: return jr - (jr % 4);
`endif
        endcase
    endfunction

    task automatic model_reset();
        m_pc      = PC_BASE;
        m_boot    = 1'b1;
        m_halted  = 1'b0;
        m_faulted = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_idx;
        exp_idx = ((m_pc - PC_BASE) / 4) % (32'd1 << ADDR_W);
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".pc4"}, bus.pc4, m_pc + 32'd4);
        chk({tag, ".im_addr"}, 32'(bus.im_addr), exp_idx);
        chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid),
            32'(!m_boot && !m_halted && !m_faulted));
        chk({tag, ".fault"}, 32'(bus.fault), 32'(m_faulted));
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, compare at next falling edge.
    task automatic step(input string tag, input logic [1:0] sel, input logic br,
                        input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr,
                        input logic stl, input logic hlt);
        logic [31:0] npc;
        bus.npc_sel     = sel;
        bus.br_taken    = br;
        bus.imm16       = imm;
        bus.instr_index = idx;
        bus.jr_target   = jr;
        bus.stall       = stl;
        bus.halt        = hlt;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halted && !m_faulted) begin
            if (hlt) begin
                m_halted = 1'b1;
            end else if (!stl) begin
                npc = model_npc(sel, br, imm, idx, jr);
`ifdef IFU_FAULT_EN
                if (npc % 4 != 0 || npc < PC_BASE ||
                    longint'(npc) >= longint'(PC_BASE) + 4 * longint'(IM_WORDS)) begin
                    m_faulted = 1'b1;
                end
`endif
                m_pc = npc;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic seq(input string tag);
        step(tag, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between clock edges; outputs must change without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".async_pc"}, bus.pc, PC_BASE);
        chk({tag, ".async_fv"}, 32'(bus.fetch_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_model({tag, ".boot"});
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.halt        = 1'b0;
        bus.npc_sel     = 2'd0;
        bus.br_taken    = 1'b0;
        bus.imm16       = 16'h0;
        bus.instr_index = 26'h0;
        bus.jr_target   = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Boot then sequential fetch.
        check_model("t1.c0");
        chk("t1.c0_pc", bus.pc, 32'h3000);
        seq("t1.c1");
        chk("t1.c1_fv", 32'(bus.fetch_valid), 32'd1);
        chk("t1.c1_pc", bus.pc, 32'h3000);
        seq("t1.c2");
        chk("t1.c2_pc", bus.pc, 32'h3004);
        chk("t1.c2_im", 32'(bus.im_addr), 32'd1);

        // Branch taken backwards, then not taken.
        repeat (3) seq("t2.seq");
        chk("t2.at", bus.pc, 32'h3010);
        step("t2.bt", 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("t2.bt_pc", bus.pc, 32'h3004);
        repeat (3) seq("t2.seq2");
        step("t2.bn", 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("t2.bn_pc", bus.pc, 32'h3014);

        // jr back to 0x3008, then j to 0x3100.
        step("t3.jr", 2'd3, 1'b0, 16'h0, 26'h0, 32'h3008, 1'b0, 1'b0);
        chk("t3.pc4", bus.pc4, 32'h300C);
        step("t3.j", 2'd2, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b0, 1'b0);
        chk("t3.j_pc", bus.pc, 32'h3100);
        chk("t3.j_im", 32'(bus.im_addr), 32'h40);

        // Stall holds a pending jump; halt beats stall and freezes the PC.
        repeat (3) step("t4.stall", 2'd2, 1'b0, 16'h0, 26'h0000C48, 32'h0, 1'b1, 1'b0);
        chk("t4.stall_pc", bus.pc, 32'h3100);
        step("t4.rel", 2'd2, 1'b0, 16'h0, 26'h0000C48, 32'h0, 1'b0, 1'b0);
        chk("t4.rel_pc", bus.pc, 32'h3120);
        step("t4.halt", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("t4.frozen", 2'($urandom), 1'b1, 16'($urandom), 26'($urandom), $urandom,
                 1'b0, 1'($urandom));
            chk("t4.frozen_pc", bus.pc, 32'h3120);
            chk("t4.frozen_fv", 32'(bus.fetch_valid), 32'd0);
        end

        // Mid-cycle reset while running at 0x3020.
        do_reset("t5.r0");
        seq("t5.boot");
        repeat (8) seq("t5.seq");
        chk("t5.at", bus.pc, 32'h3020);
        do_reset("t5.r1");

        // Unaligned jr target.
        seq("t6.boot");
        step("t6.jr", 2'd3, 1'b0, 16'h0, 26'h0, 32'h3006, 1'b0, 1'b0);
`ifdef IFU_FAULT_EN
        chk("t6.pc", bus.pc, 32'h3006);
        chk("t6.fault", 32'(bus.fault), 32'd1);
        chk("t6.fv", 32'(bus.fetch_valid), 32'd0);
        step("t6.sticky", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        chk("t6.sticky_fault", 32'(bus.fault), 32'd1);
`else
        chk("t6.pc", bus.pc, 32'h3004);
        chk("t6.fault", 32'(bus.fault), 32'd0);
        chk("t6.fv", 32'(bus.fetch_valid), 32'd1);
`endif

        // Randomized traffic, with resets whenever the model gets stuck.
        do_reset("rnd.r");
        for (int i = 0; i < 400; i++) begin
            if (m_halted || m_faulted || $urandom_range(0, 49) == 0) begin
                do_reset("rnd.r");
            end else begin
                step("rnd",
                     2'($urandom),
                     1'($urandom),
                     16'($urandom),
                     ($urandom_range(0, 1) == 1) ? 26'((PC_BASE >> 2) + $urandom_range(0, 1023))
                                                 : 26'($urandom),
                     PC_BASE + $urandom_range(0, 4200),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
